// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//
// Shares one UART transmitter between two byte-stream requesters:
//   requester 0 = command processor reply path
//   requester 1 = trigger-event streamer
// Ownership is granted per packet with round-robin priority. Each byte is
// handed to the UART with a one-cycle txStart pulse. An owner whose valid
// stays low for TIMEOUT LOAD cycles loses the grant.
//
// Handshake: a requester byte moves when valid and ready are both high
// on a rising edge. ready is combinational and only the current owner
// ever sees it, only in LOAD, and only while txBusy is low. valid of a
// non-owner is left pending and is never consumed or dropped.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   reqN_valid/data/last requester N byte stream (N = 0, 1)
//   reqN_ready           byte consumed this cycle
//   txBusy               UART busy (sampled only in LOAD)
//   txStart              one-cycle start pulse to UART
//   txData               byte to UART, held until the next capture
//   grant                one-hot current owner, 00 when idle
//   timeout              one-cycle pulse on forced release
module serial_tx_arbiter #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    input  logic       txBusy,
    output logic       txStart,
    output logic [7:0] txData,
    output logic [1:0] grant,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic        timeout_q;
    logic        last_q;       // index of the requester served most recently
    logic        last_flag_q;  // byte in flight closes the packet
    logic [15:0] idle_cnt_q;

    logic       owner_valid;
    logic [7:0] owner_data;
    logic       owner_last;
    logic       owner_idx;
    logic       load_take;

    always_comb begin
        owner_valid = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);
        owner_data  = grant_q[1] ? req1_data : req0_data;
        owner_last  = grant_q[1] ? req1_last : req0_last;
        owner_idx   = grant_q[1];
        load_take   = (state_q == LOAD) && owner_valid && !txBusy;
        req0_ready  = load_take && grant_q[0];
        req1_ready  = load_take && grant_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            timeout_q   <= 1'b0;
            last_q      <= 1'b1;
            last_flag_q <= 1'b0;
            idle_cnt_q  <= 16'h0000;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // On a tie the requester that was not served last wins.
                    if (req0_valid || req1_valid) begin
                        if (req0_valid && req1_valid) begin
                            grant_q <= last_q ? 2'b01 : 2'b10;
                        end else if (req0_valid) begin
                            grant_q <= 2'b01;
                        end else begin
                            grant_q <= 2'b10;
                        end
                        idle_cnt_q <= 16'h0000;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (owner_valid) begin
                        // Busy UART: wait with the idle counter frozen.
                        if (!txBusy) begin
                            tx_data_q   <= owner_data;
                            last_flag_q <= owner_last;
                            tx_start_q  <= 1'b1;
                            idle_cnt_q  <= 16'h0000;
                            state_q     <= START;
                        end
                    end else if (idle_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        last_q    <= owner_idx;
                        grant_q   <= 2'b00;
                        state_q   <= IDLE;
                    end else if (idle_cnt_q != 16'hFFFF) begin
                        idle_cnt_q <= idle_cnt_q + 16'd1;
                    end
                end
                START: begin
                    state_q <= GAP;
                end
                GAP: begin
                    if (last_flag_q) begin
                        last_q  <= owner_idx;
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txStart = tx_start_q;
    assign txData  = tx_data_q;
    assign grant   = grant_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter (TIMEOUT = 8).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge (registered outputs) or 1 time unit later (combinational ready).
module tb_serial_tx_arbiter;

    logic       clk;
    logic       reset;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       txBusy;
    logic       txStart;
    logic [7:0] txData;
    logic [1:0] grant;
    logic       timeout;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    logic [7:0] exp0_q[$];
    logic [7:0] exp1_q[$];
    logic [1:0] grant_log[$];
    int         start_log[$];
    int         acc_log[$];

    serial_tx_arbiter #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .txBusy     (txBusy),
        .txStart    (txStart),
        .txData     (txData),
        .grant      (grant),
        .timeout    (timeout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    // Called on a falling edge; returns on the falling edge after the byte
    // was consumed, with valid dropped.
    task automatic drive_byte(input int r, input logic [7:0] d, input logic l);
        bit got_it;
        got_it = 1'b0;
        if (r == 0) begin
            req0_valid = 1'b1; req0_data = d; req0_last = l; exp0_q.push_back(d);
        end else begin
            req1_valid = 1'b1; req1_data = d; req1_last = l; exp1_q.push_back(d);
        end
        for (int c = 0; c < 200; c++) begin
            #1;
            if ((r == 0) ? req0_ready : req1_ready) begin
                got_it = 1'b1;
                acc_log.push_back(cyc);
                break;
            end
            @(negedge clk);
        end
        if (got_it) @(negedge clk);
        else check("ready_wait", 32'd0, 32'd1);
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (txStart === 1'b1) begin
            start_log.push_back(cyc);
            grant_log.push_back(grant);
            if (grant == 2'b01) begin
                if (exp0_q.size() == 0) check("tx_extra0", {24'd0, txData}, 32'hFFFF);
                else check("tx_data0", {24'd0, txData}, {24'd0, exp0_q.pop_front()});
            end else if (grant == 2'b10) begin
                if (exp1_q.size() == 0) check("tx_extra1", {24'd0, txData}, 32'hFFFF);
                else check("tx_data1", {24'd0, txData}, {24'd0, exp1_q.pop_front()});
            end else begin
                check("start_grant", {30'd0, grant}, 32'd1);
            end
        end
    end

    task automatic check_grant_log(input string tag, input logic [1:0] exp_g[$]);
        check({tag, "_len"}, grant_log.size(), exp_g.size());
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check(tag, {30'd0, grant_log[i]}, {30'd0, exp_g[i]});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v;
        logic [1:0] eg[$];
        reset = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        txBusy = 1'b0;

        // Reset values (valids high during reset: still nothing is granted)
        @(negedge clk);
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_txstart", {31'd0, txStart}, 32'd0);
        check("rst_txdata", {24'd0, txData}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single packet: 3-cycle cadence and grant release
        acc_log.delete(); start_log.delete();
        v = cyc;
        drive_byte(0, 8'h07, 1'b0);
        drive_byte(0, 8'h01, 1'b0);
        drive_byte(0, 8'h02, 1'b1);
        @(negedge clk);
        check("sp_grant_gap", {30'd0, grant}, 32'd1);
        @(negedge clk);
        check("sp_grant_idle", {30'd0, grant}, 32'd0);
        check("sp_acc_len", acc_log.size(), 32'd3);
        check("sp_start_len", start_log.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("sp_acc_cyc", acc_log[i], v + 1 + 3 * i);
            check("sp_start_cyc", start_log[i], v + 2 + 3 * i);
        end

        // Contention from reset: req0 first, then req1, no interleave
        do_reset();
        grant_log.delete();
        fork
            begin drive_byte(0, 8'hA0, 1'b0); drive_byte(0, 8'hA1, 1'b1); end
            begin drive_byte(1, 8'hB0, 1'b0); drive_byte(1, 8'hB1, 1'b1); end
        join
        repeat (3) @(negedge clk);
        eg = '{2'b01, 2'b01, 2'b10, 2'b10};
        check_grant_log("rr1_grant", eg);

        // Round robin: req0 keeps requesting but req1 gets the next packet
        grant_log.delete();
        fork
            begin
                drive_byte(0, 8'hC0, 1'b0); drive_byte(0, 8'hC1, 1'b1);
                drive_byte(0, 8'hD0, 1'b0); drive_byte(0, 8'hD1, 1'b1);
            end
            begin drive_byte(1, 8'hE0, 1'b0); drive_byte(1, 8'hE1, 1'b1); end
        join
        repeat (3) @(negedge clk);
        eg = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        check_grant_log("rr2_grant", eg);

        // Backpressure: txBusy high for 20 cycles mid-packet
        fork
            begin
                drive_byte(0, 8'hF1, 1'b0); drive_byte(0, 8'hF2, 1'b0); drive_byte(0, 8'hF3, 1'b1);
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int c = 0; c < 20 && !seen; c++) begin
                    @(negedge clk);
                    if (txStart === 1'b1) seen = 1'b1;
                end
                check("bp_first_start", {31'd0, seen}, 32'd1);
                txBusy = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    #1;
                    check("bp_ready", {31'd0, req0_ready}, 32'd0);
                    check("bp_txstart", {31'd0, txStart}, 32'd0);
                    check("bp_timeout", {31'd0, timeout}, 32'd0);
                end
                @(negedge clk);
                txBusy = 1'b0;
                #1;
                check("bp_resume_ready", {31'd0, req0_ready}, 32'd1);
            end
        join
        repeat (3) @(negedge clk);

        // Timeout: req1 stalls after a non-last byte, req0 waits
        drive_byte(1, 8'h55, 1'b0);
        req0_valid = 1'b1; req0_data = 8'h66; req0_last = 1'b1;
        exp0_q.push_back(8'h66);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("to_pulse", {31'd0, timeout}, (k == 10) ? 32'd1 : 32'd0);
            if (k == 9) check("to_grant_held", {30'd0, grant}, 32'd2);
        end
        check("to_grant_clear", {30'd0, grant}, 32'd0);
        @(negedge clk);
        check("to_pulse_once", {31'd0, timeout}, 32'd0);
        check("to_regrant", {30'd0, grant}, 32'd1);
        #1;
        check("to_ready0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during START of byte 2 of a 4-byte packet
        drive_byte(0, 8'h11, 1'b0);
        drive_byte(0, 8'h22, 1'b0);
        check("mr_in_start", {31'd0, txStart}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_txstart", {31'd0, txStart}, 32'd0);
        check("mr_grant", {30'd0, grant}, 32'd0);
        check("mr_txdata", {24'd0, txData}, 32'd0);
        check("mr_pending", exp0_q.size(), 32'd0);
        @(negedge clk);
        drive_byte(0, 8'h33, 1'b0);
        drive_byte(0, 8'h44, 1'b1);
        repeat (4) @(negedge clk);
        check("mr_after_grant", {30'd0, grant}, 32'd0);

        check("end_exp0_empty", exp0_q.size(), 32'd0);
        check("end_exp1_empty", exp1_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Global guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
